// File: rtl/mprj_io_cfg_loader.sv
// Serial loader for the user-project IO pad configuration chains.
// Ports: clk/resetn; start/abort/chain_rst/clk_div control; cfg_idx/cfg_data
// fetch the config word for each pad; ld_* drive the serial chains; busy/done
// report progress. Pads go out from PADS-1 down to 0, each pad MSB first.
// PADS and BITS must both be at least 2.
module mprj_io_cfg_loader #(
    parameter int CHAINS = 2,
    parameter int PADS   = 19,
    parameter int BITS   = 13
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     chain_rst,
    input  logic [7:0]               clk_div,
    output logic [$clog2(PADS)-1:0]  cfg_idx,
    input  logic [CHAINS*BITS-1:0]   cfg_data,
    output logic                     ld_resetn,
    output logic                     ld_clock,
    output logic [CHAINS-1:0]        ld_data,
    output logic                     ld_load,
    output logic                     busy,
    output logic                     done
);

    localparam int PW = $clog2(PADS);
    localparam int BW = $clog2(BITS);

    typedef enum logic [2:0] {
        S_IDLE, S_RST, S_FETCH, S_LOW, S_HIGH, S_LOAD, S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_state_n;
    logic [7:0]             r_div;
    logic [7:0]             r_cnt;
    logic [PW-1:0]          r_pad;
    logic [BW-1:0]          r_bit;
    logic [CHAINS*BITS-1:0] r_sh;
    logic [CHAINS-1:0]      r_ld_data;
    logic [CHAINS-1:0]      w_msb;
    logic                   w_phase_end;
    logic                   w_accept;

    // r_div is never zero once a load is running, so this cannot underflow
    // in any timed state.
    assign w_phase_end = (r_cnt == r_div - 8'd1);
    assign w_accept    = (r_state == S_IDLE) && start && !abort;

    always_comb begin
        w_msb = '0;
        for (int c = 0; c < CHAINS; c++) begin
            w_msb[c] = r_sh[c*BITS + BITS - 1];
        end
    end

    always_comb begin
        w_state_n = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) w_state_n = chain_rst ? S_RST : S_FETCH;
            end
            S_RST: begin
                if (w_phase_end) w_state_n = S_FETCH;
            end
            S_FETCH: w_state_n = S_LOW;
            S_LOW: begin
                if (w_phase_end) w_state_n = S_HIGH;
            end
            S_HIGH: begin
                if (w_phase_end) begin
                    if (r_bit != '0)      w_state_n = S_LOW;
                    else if (r_pad != '0) w_state_n = S_FETCH;
                    else                  w_state_n = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_phase_end) w_state_n = S_DONE;
            end
            S_DONE:  w_state_n = S_IDLE;
            default: w_state_n = S_IDLE;
        endcase
        if (abort) w_state_n = S_IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_div     <= 8'd0;
            r_cnt     <= 8'd0;
            r_pad     <= '0;
            r_bit     <= '0;
            r_sh      <= '0;
            r_ld_data <= '0;
        end else begin
            r_state <= w_state_n;
            // Phase timer restarts on every state change.
            if (w_state_n != r_state || r_state == S_IDLE) r_cnt <= 8'd0;
            else                                           r_cnt <= r_cnt + 8'd1;
            if (w_accept) begin
                r_div <= (clk_div == 8'd0) ? 8'd1 : clk_div;
                r_pad <= PW'(PADS - 1);
            end
            if (r_state == S_FETCH && !abort) begin
                r_sh  <= cfg_data;
                r_bit <= BW'(BITS - 1);
            end
            // Hold the LOW-phase bit so ld_data stays put through HIGH/FETCH.
            if (r_state == S_LOW) r_ld_data <= w_msb;
            if (r_state == S_HIGH && w_phase_end && !abort) begin
                for (int c = 0; c < CHAINS; c++) begin
                    r_sh[c*BITS +: BITS] <= r_sh[c*BITS +: BITS] << 1;
                end
                if (r_bit != '0)      r_bit <= r_bit - BW'(1);
                else if (r_pad != '0) r_pad <= r_pad - PW'(1);
            end
        end
    end

    assign cfg_idx   = r_pad;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign ld_clock  = (r_state == S_HIGH);
    assign ld_load   = (r_state == S_LOAD);
    assign ld_resetn = (r_state != S_RST);
    assign ld_data   = (r_state == S_LOW) ? w_msb : r_ld_data;

endmodule
